// File: rtl/dram_wr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM DDR3 write port among N_CH reorder buffers.
// Define DRAM_ARB_STATS_EN to add per-channel burst counters and a stall-cycle counter.
module dram_wr_arbiter #(
  parameter int N_CH      = 2,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 256,
  parameter int CH_BITS   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          bram_ready_mask,
  input  logic [N_CH*DATA_W-1:0]   bram_rd_data,
  output logic [N_CH-1:0]          bram_rd_request,
  output logic [CH_BITS-1:0]       bram_sel,
  output logic                     avl_write,
  output logic                     avl_beginbursttransfer,
  output logic [4:0]               avl_burstcount,
  output logic [ADDR_W-1:0]        avl_address,
  output logic [DATA_W-1:0]        avl_writedata,
  input  logic                     avl_waitrequest_n,
  output logic                     busy
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [N_CH*32-1:0]       burst_count_flat,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int CB = $clog2(N_CH);
  localparam int RB = ADDR_W - CB;
  localparam int CW = $clog2(BURST_LEN) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  localparam logic [CW-1:0] BL    = CW'(BURST_LEN);
  localparam logic [CW-1:0] BL_M1 = CW'(BURST_LEN - 1);

  logic [1:0]        state;
  logic [CB-1:0]     rr_ptr;
  logic [CB-1:0]     gnt_q;
  logic [CB-1:0]     sel_q;
  logic [CB-1:0]     pick;
  logic [CB-1:0]     idx;
  logic              found;
  logic [RB-1:0]     ptr [N_CH];
  logic [CW-1:0]     fetch_cnt;
  logic [CW-1:0]     beat_cnt;
  logic              req_q;
  logic              started;
  logic [DATA_W-1:0] fifo [2];
  logic              wr_idx;
  logic              rd_idx;
  logic [1:0]        occ;
  logic [DATA_W-1:0] rd_word;
  logic              fetch;
  logic              push;
  logic              pop;
  logic              last;

  // First ready buffer at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = rr_ptr + CB'(k);
      if (!found && bram_ready_mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign rd_word = bram_rd_data[int'(sel_q)*DATA_W +: DATA_W];

  // At most two words live between the buffer read port and the FIFO.
  assign fetch = (state == BURST) && (fetch_cnt < BL) &&
                 (({1'b0, occ} + {2'b00, req_q}) < 3'd2);

  assign bram_rd_request = fetch ? (N_CH'(1) << sel_q) : '0;

  assign push = req_q;
  assign avl_write = (state == BURST) && (occ != 2'd0);
  assign pop  = avl_write && avl_waitrequest_n;
  assign last = pop && (beat_cnt == BL_M1);

  assign avl_writedata  = fifo[rd_idx];
  assign avl_burstcount = avl_write ? 5'(BURST_LEN) : 5'd0;
  assign avl_beginbursttransfer = avl_write && !started;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_q       <= '0;
      sel_q       <= '0;
      bram_sel    <= '0;
      avl_address <= '0;
      fetch_cnt   <= '0;
      beat_cnt    <= '0;
      req_q       <= 1'b0;
      started     <= 1'b0;
      for (int i = 0; i < N_CH; i++) ptr[i] <= '0;
    end else begin
      req_q <= fetch;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          sel_q       <= gnt_q;
          bram_sel    <= CH_BITS'(gnt_q);
          avl_address <= (ADDR_W'(gnt_q) << RB) | ADDR_W'(ptr[gnt_q]);
          fetch_cnt   <= '0;
          beat_cnt    <= '0;
          started     <= 1'b0;
          rr_ptr      <= gnt_q + CB'(1);
          state       <= BURST;
        end
        BURST: begin
          if (fetch) fetch_cnt <= fetch_cnt + CW'(1);
          if (pop) beat_cnt <= beat_cnt + CW'(1);
          if (avl_write) started <= 1'b1;
          // Region pointer wraps naturally at RB bits.
          if (last) begin
            ptr[sel_q] <= ptr[sel_q] + RB'(BURST_LEN);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_idx  <= 1'b0;
      rd_idx  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_idx] <= rd_word;
        wr_idx       <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] done_cnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) done_cnt[i] <= '0;
      stall_cycles <= '0;
    end else begin
      if (last) done_cnt[sel_q] <= done_cnt[sel_q] + 32'd1;
      if (avl_write && !avl_waitrequest_n && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_flat
    assign burst_count_flat[g*32 +: 32] = done_cnt[g];
  end
`endif

endmodule

// File: doc/dram_wr_arbiter.md
Name: dram_wr_arbiter

Overview:
- Shares the single Avalon-MM DDR3 write port among N_CH channel reorder buffers using round-robin arbitration.
- Per grant: pops exactly BURST_LEN 256-bit words from the granted buffer, then issues one Avalon write burst.
- Each channel writes into its own DRAM address region, walked by a private wrapping pointer.
- Sits between the per-channel reorder buffers and the DDR3 controller's Avalon slave, in the avalon_clk domain.

Parameters:
- N_CH, 2, number of channel buffers; power of 2, range 2..8.
- BURST_LEN, 16, words per burst; power of 2, range 1..16.
- ADDR_W, 25, Avalon word address width.
- DATA_W, 256, data word width.
- CH_BITS, 3, width of bram_sel; must be ≥ clog2(N_CH).

Ports:
- clk  in  1  avalon_clk domain clock.
- rst_n  in  1  asynchronous active-low reset.
- bram_ready_mask  in  N_CH  bit i=1: buffer i holds ≥ BURST_LEN words.
- bram_rd_data  in  N_CH*DATA_W  flattened buffer read data; channel i at [i*DATA_W +: DATA_W]; valid 1 cycle after its rd_request.
- bram_rd_request  out  N_CH  one-hot pop strobe, one word per cycle high.
- bram_sel  out  CH_BITS  granted channel index.
- avl_write  out  1  Avalon write.
- avl_beginbursttransfer  out  1  Avalon burst begin.
- avl_burstcount  out  5  equals BURST_LEN while avl_write is high.
- avl_address  out  ADDR_W  burst start word address.
- avl_writedata  out  DATA_W  write data.
- avl_waitrequest_n  in  1  1 = slave accepts the current beat.
- busy  out  1  high from GRANT until the last beat is accepted.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; rr_ptr=0; all channel pointers=0; FIFO emptied; fetch/beat counters 0. An in-flight burst is abandoned and not resumed.
- Regions: channel c base = c << (ADDR_W-clog2(N_CH)); region size 2^(ADDR_W-clog2(N_CH)) words.
- Burst address = base + ptr[c]. ptr[c] += BURST_LEN at burst completion, modulo region size. Wrap lands exactly on 0; a burst never straddles regions.
- FSM IDLE: if any ready bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, … (mod N_CH) -> GRANT. Otherwise stay in IDLE.
- FSM GRANT (1 cycle):
  - register bram_sel and avl_address;
  - clear fetch_cnt and beat_cnt;
  - rr_ptr = granted+1 mod N_CH;
  - busy=1; -> BURST.
- FSM BURST, fetch side:
  - assert bram_rd_request[sel] when fetch_cnt < BURST_LEN and (FIFO occupancy + outstanding) < 2; fetch_cnt++.
  - Returning data is muxed by sel and written into a 2-entry FIFO the following cycle.
- FSM BURST, write side:
  - avl_write=1 whenever the FIFO is non-empty; avl_writedata = FIFO head.
  - A beat is accepted when avl_write && avl_waitrequest_n: pop FIFO, beat_cnt++.
  - While waitrequest_n=0, hold avl_write, avl_writedata, avl_address and avl_burstcount stable.
- avl_beginbursttransfer: high exactly one cycle, the first cycle avl_write rises in a burst, regardless of waitrequest_n.
- On the beat where beat_cnt reaches BURST_LEN-1 and it is accepted: update ptr[sel]; -> IDLE; busy=0 the next cycle. IDLE re-arbitrates immediately, giving at least 2 idle cycles between bursts.
- bram_ready_mask is only sampled in IDLE. Deassertion during BURST is ignored; the buffer guarantees it has BURST_LEN words.
- Never more than 2 words in flight; the FIFO can never overflow.

Optional Feature:
- Macro DRAM_ARB_STATS_EN.
- Defined:
  - adds output burst_count_flat (N_CH*32): per-channel completed-burst counters, reset 0, incremented on the final accepted beat, wrapping at 2^32;
  - adds output stall_cycles (32): counts cycles with avl_write=1 and avl_waitrequest_n=0, saturating at 2^32-1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single channel: ready=2'b01, waitrequest_n=1, words 0x1..0x10 → one burst: address 0, burstcount 16, data 0x1..0x10 in order, beginbursttransfer one cycle, exactly 16 rd_request pulses; ptr[0]=16.
- Fairness: ready=2'b11 held for 4 bursts → grant order 0,1,0,1; channel-1 addresses 0x1000000, then 0x1000010.
- Stall: waitrequest_n=0 for cycles 3–7 of the burst → write/data/address held stable, no word lost or duplicated, never more than 2 words fetched ahead.
- Wrap: preload ptr[0] to 0xFFFFF0 (N_CH=2) → burst at 0xFFFFF0, next burst at 0x000000.
- Reset mid-burst: rst_n low after beat 5 → all outputs 0 asynchronously; after release, a ready channel bursts at its region base with rr_ptr=0.
- Stats (DRAM_ARB_STATS_EN): 3 bursts on ch0, 1 on ch1, 5 stall cycles → counters 3, 1, stall_cycles=5.
